// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Stall, bubble and flush sequencing for a 5-stage MIPS pipeline.
//   - load-use hazards between the load in EX and the instruction in ID
//   - pipeline freeze while a multi-cycle mul/div sits in EX
//   - IF/ID flush on a taken branch resolved in ID
//   - saturating stall-cycle and flush performance counters
//
// Ports
//   clk_i            pipeline clock
//   rst_ni           asynchronous active-low reset
//   id_rs_i/id_rt_i  source register fields of the ID instruction
//   id_uses_rs_i/_rt_i  ID instruction actually reads Rs/Rt
//   ex_mem_read_i    EX instruction is a load
//   ex_write_reg_i   destination register of the EX instruction
//   ex_muldiv_i      EX instruction is a mul/div (held while it stays in EX)
//   branch_taken_i   branch in ID resolved taken this cycle
//   perf_clr_i       synchronous clear of both performance counters
//   pc_write_o, if_id_write_o, id_ex_write_o   register enables
//   if_id_flush_o, id_ex_bubble_o, ex_mem_bubble_o  NOP/flush controls
//   busy_o           FSM is in BUSY
//   stall_cycles_o   cycles with pc_write_o low (saturating)
//   flush_count_o    taken-branch flushes (saturating)
//
// state | meaning
// RUN   | normal flow; a new mul/div in EX starts a freeze
// BUSY  | mul/div occupying EX; cnt_q holds remaining freeze cycles,
//       | cnt_q==0 is the release cycle
module hazard_stall_controller #(
    parameter int MULDIV_LATENCY = 4,
    parameter int CNT_W          = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rs_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_mem_read_i,
    input  logic [4:0]       ex_write_reg_i,
    input  logic             ex_muldiv_i,
    input  logic             branch_taken_i,
    input  logic             perf_clr_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_write_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_bubble_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o
);

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } state_e;

    // The first mul/div cycle is spent in RUN, so BUSY covers the rest.
    localparam int          RELOAD_I  = (MULDIV_LATENCY > 1) ? (MULDIV_LATENCY - 2) : 0;
    localparam logic [3:0]  RELOAD    = 4'(RELOAD_I);
    localparam logic        MULTI_CYC = (MULDIV_LATENCY > 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic lu;
    logic hold;

    always_comb begin
        lu = ex_mem_read_i && (ex_write_reg_i != 5'd0) &&
             ((id_uses_rs_i && (id_rs_i == ex_write_reg_i)) ||
              (id_uses_rt_i && (id_rt_i == ex_write_reg_i)));
    end

    // ex_muldiv_i is only looked at in RUN so a still-high input during
    // the release cycle cannot retrigger the freeze.
    always_comb begin
        if (state_q == RUN) hold = ex_muldiv_i && MULTI_CYC;
        else                hold = (cnt_q != 4'd0);
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pc_write_o      = 1'b1;
        if_id_write_o   = 1'b1;
        id_ex_write_o   = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_bubble_o  = 1'b0;
        ex_mem_bubble_o = 1'b0;
        busy_o          = (state_q == BUSY);

        if (hold) begin
            pc_write_o      = 1'b0;
            if_id_write_o   = 1'b0;
            id_ex_write_o   = 1'b0;
            ex_mem_bubble_o = 1'b1;
            if (state_q == RUN) begin
                state_d = BUSY;
                cnt_d   = RELOAD;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else begin
            if (state_q == BUSY) state_d = RUN;
            if (lu) begin
                pc_write_o     = 1'b0;
                if_id_write_o  = 1'b0;
                id_ex_bubble_o = 1'b1;
            end else if (branch_taken_i) begin
                // A stalled cycle drops the branch; ID re-resolves it next cycle.
                if_id_flush_o = 1'b1;
            end
        end

        // Outputs are forced idle for the whole time reset is asserted.
        if (!rst_ni) begin
            pc_write_o      = 1'b1;
            if_id_write_o   = 1'b1;
            id_ex_write_o   = 1'b1;
            if_id_flush_o   = 1'b0;
            id_ex_bubble_o  = 1'b0;
            ex_mem_bubble_o = 1'b0;
            busy_o          = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (perf_clr_i) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (!pc_write_o && (stall_q != '1)) stall_d = stall_q + 1'b1;
            if (if_id_flush_o && (flush_q != '1)) flush_d = flush_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_count_o  = flush_q;

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Sequences pipeline stalls, bubbles and flushes for the 5-stage MIPS pipeline, alongside the EX-stage forwarding logic.
- Detects load-use hazards that forwarding cannot cover.
- Freezes the pipe while a multi-cycle mul/div occupies EX.
- Flushes IF/ID on a taken branch resolved in ID.
- Keeps saturating performance counters of stall and flush events.

Parameters:
MULDIV_LATENCY, 4, total EX-stage cycles of a mul/div including its first cycle; legal range 1..15.
CNT_W, 16, width of each performance counter.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
id_rs  input  5  Rs field of the instruction in ID.
id_rt  input  5  Rt field of the instruction in ID.
id_uses_rs  input  1  ID instruction reads Rs.
id_uses_rt  input  1  ID instruction reads Rt.
ex_mem_read  input  1  instruction in EX is a load.
ex_write_reg  input  5  destination register of the instruction in EX.
ex_muldiv  input  1  instruction in EX is a mul/div; held high while it remains in EX.
branch_taken  input  1  branch in ID resolved taken this cycle.
perf_clr  input  1  synchronous clear of both counters.
pc_write  output  1  PC update enable.
if_id_write  output  1  IF/ID register enable.
if_id_flush  output  1  zero IF/ID on the next edge.
id_ex_write  output  1  ID/EX register enable.
id_ex_bubble  output  1  load NOP into ID/EX on the next edge.
ex_mem_bubble  output  1  load NOP into EX/MEM on the next edge.
busy  output  1  FSM in BUSY state.
stall_cycles  output  CNT_W  cycles with pc_write=0, saturating.
flush_count  output  CNT_W  taken-branch flushes, saturating.

Behaviour:
- FSM states: RUN, BUSY.
- Down-counter cnt is 4 bits wide.
- All outputs are combinational from state, cnt and the inputs; registers are state, cnt and the two counters.

Reset:
- rst_n=0 forces state=RUN, cnt=0, counters=0, immediately and asynchronously, including in the middle of BUSY.
- While rst_n=0 the outputs take idle values: pc_write=if_id_write=id_ex_write=1; if_id_flush=id_ex_bubble=ex_mem_bubble=busy=0.

Load-use hazard (lu):
- lu = ex_mem_read & (ex_write_reg!=0) & ((id_uses_rs & id_rs==ex_write_reg) | (id_uses_rt & id_rt==ex_write_reg)).
- A destination of $0 never causes a stall.

Mul/div hold (hold):
- In RUN: hold = ex_muldiv & (MULDIV_LATENCY>1).
- In BUSY: hold = (cnt!=0).

RUN state, priority hold > lu > branch_taken:
- hold: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1. Next state BUSY with cnt <= MULDIV_LATENCY-2.
- lu (no hold): pc_write=0, if_id_write=0, id_ex_bubble=1. Stays in RUN. Exactly one bubble per hazard; the condition clears once the load leaves EX.
- branch_taken (no hold, no lu): if_id_flush=1; pc_write=1, so the PC takes the target.
- Any stall suppresses branch_taken; ID re-evaluates the branch next cycle with fresh operands.

BUSY state:
- cnt!=0: hold outputs as above, cnt decrements.
- cnt==0 (release cycle): no hold; lu and branch rules apply as in RUN; next state RUN.
- ex_muldiv is ignored throughout BUSY, so a still-high ex_muldiv never retriggers.
- Total hold cycles per mul/div = MULDIV_LATENCY-1; MULDIV_LATENCY=1 never stalls.
- A back-to-back mul/div is recognised in the RUN cycle after release.

Counters:
- stall_cycles increments on each edge where pc_write=0.
- flush_count increments on each edge where if_id_flush=1.
- Both saturate at all-ones.
- perf_clr wins over increment in the same cycle.

Test Plan:
- Load-use: ex_mem_read=1, ex_write_reg=8, id_rs=8, id_uses_rs=1 -> same cycle pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cycles 0->1. With id_uses_rs=0 -> no stall.
- $zero: ex_mem_read=1, ex_write_reg=0, id_rt=0, id_uses_rt=1 -> pc_write=1, id_ex_bubble=0.
- Mul/div, L=4: ex_muldiv high from cycle 0 through cycle 3 -> ex_mem_bubble=1 and pc_write=0 in cycles 0-2; busy=1 in cycles 1-3; cycle 3 releases with pc_write=1; stall_cycles +3; with ex_muldiv still high in cycle 3, no retrigger. Repeat with L=1 -> no stall at all.
- Branch vs stall: cycle 0 lu=1 with branch_taken=1 -> no flush, id_ex_bubble=1. Cycle 1 lu=0 with branch_taken=1 -> if_id_flush=1, pc_write=1; flush_count=1.
- Reset mid-BUSY: L=4, drop rst_n in cycle 1 -> outputs idle immediately, busy=0, counters 0. Release reset with ex_muldiv=1 -> fresh sequence of 3 hold cycles.
- Saturation: CNT_W=4, hold lu for 20 cycles -> stall_cycles=15 and stays at 15. Assert perf_clr on a stall cycle -> 0 on the next edge.
